gpioemu_mulx: RTL and testbench
===============================

Name: gpioemu_mulx

Overview:
Parametrised successor of the GPIO-emulator arithmetic peripheral. It multiplies two memory-mapped unsigned operands of configurable width with a sequential shift-add engine, then counts ones in the full product. It exposes product, popcount and status through the same saddress/srd/swr bus, and keeps the gpio_in latch and gpio_out counter. Unlike the previous generation, it is fully synchronous, start-triggered, busy-protected and width-generic, and it exposes the product high word.

Parameters:
OPW, 24, operand width in bits, legal range 8..32; derived RW = 2*OPW product width, PCW = clog2(RW+1) popcount width
ADDR_A1, 16'h037F, operand 1 register (R/W)
ADDR_A2, 16'h0388, operand 2 register (R/W)
ADDR_W, 16'h0390, product bits [31:0] (RO)
ADDR_L, 16'h0398, popcount of full product (RO)
ADDR_CTRL, 16'h03A0, write = start; read = status
ADDR_WH, 16'h03A8, product bits [RW-1:32], zero-extended; reads 0 when RW<=32 (RO)

Ports:
clk  in  1  system clock; all logic on rising edge
n_reset  in  1  asynchronous active-low reset
saddress  in  16  bus address
srd  in  1  read strobe, one clk cycle wide
swr  in  1  write strobe, one clk cycle wide
sdata_in  in  32  write data
sdata_out  out  32  read data, registered
gpio_in  in  32  GPIO input pins
gpio_latch  in  1  capture request; rising edge detected on clk
gpio_in_s_insp  out  32  latched gpio_in snapshot
gpio_out  out  32  count of completed operations

Behaviour:
- Reset (async, n_reset=0): sdata_out=0, gpio_out=0, gpio_in_s_insp=0, A1=A2=0, W/WH/L=0, state=IDLE, status ready=1 valid=1 done=0 busy=0 err=0.
- Status word read at ADDR_CTRL: bit0 valid (product[RW-1:32]==0), bit1 ready, bit2 done (sticky), bit3 busy, bit4 err (sticky); bits 31:5 are 0. Status reads 0x3 after reset.
- Writes: A1/A2 take sdata_in[OPW-1:0]; upper bits are ignored. They are writable at any time, because the engine uses snapshots taken at start.
- A write of any data to ADDR_CTRL in IDLE is a start. It snapshots A1/A2 and clears W, WH, L, done and err. It sets busy=1, ready=0, valid=1, and the state becomes MULT on the next edge.
- A write to ADDR_CTRL while busy is ignored except that it sets err=1. It does not restart and does not count.
- MULT: one multiplier bit per cycle, LSB first; the accumulator adds the shifted multiplicand when the bit is set. Exactly OPW cycles.
- COUNT: one cycle; popcount over all RW product bits is registered into L. W, WH and valid update in the same cycle.
- DONE: one cycle; done=1, busy=0, ready=1, gpio_out+1 (wraps 0xFFFFFFFF->0); then IDLE.
- Start-to-done latency is OPW+2 cycles after the swr cycle. Status shows done=1 from the cycle after DONE.
- Reads: sdata_out is loaded on the clk edge where srd=1 and is valid from the next cycle. It holds until the next srd. Unmapped addresses return 0. A1/A2 read back zero-extended.
- srd and swr in the same cycle to the same address: the read returns the pre-write value.
- Result registers W/WH/L read their previous values while busy.
- gpio_latch: a 0->1 transition, sampled against the previous clk value, loads gpio_in into gpio_in_s_insp. A level held high does not recapture.
- Reset mid-operation aborts immediately to reset values, and gpio_out is not incremented.

Decomposition:
- Package gpioemu_pkg holds the state enum (IDLE, MULT, COUNT, DONE), default address constants and status bit indices.
- Sub-module mulx_shift_add(OPW) is the sequential shift-add multiplier with start/busy/done, instantiated once.
- Popcount, bus decode and GPIO logic stay in the top level.

Test Plan:
- Reset then read ADDR_CTRL/ADDR_W/ADDR_L -> 0x3, 0, 0; gpio_out=0.
- A1=3, A2=5, start, wait OPW+2 (26) cycles -> W=15, WH=0, L=4, status=0x7, gpio_out=1.
- A1=A2=0xFFFFFF -> W=0xFE000001, WH=0xFFFF, L=24, status valid=0 (0x6).
- Start, then a second start at cycle 5 -> single result, err=1 (status 0x16 or 0x17 per valid), gpio_out increments once.
- Start, then n_reset low at cycle 10 -> all reset values, gpio_out=0; a new start afterwards completes normally.
- gpio_in=0xA5A55A5A with a gpio_latch rising edge -> gpio_in_s_insp=0xA5A55A5A. Then change gpio_in to 0x1 with latch held high -> unchanged until the next rising edge.

Source files
------------

// File: rtl/gpioemu_pkg.sv
// Shared types and constants for the gpioemu_mulx multiply/popcount peripheral.
package gpioemu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] DEF_ADDR_A1   = 16'h037F;
  localparam logic [15:0] DEF_ADDR_A2   = 16'h0388;
  localparam logic [15:0] DEF_ADDR_W    = 16'h0390;
  localparam logic [15:0] DEF_ADDR_L    = 16'h0398;
  localparam logic [15:0] DEF_ADDR_CTRL = 16'h03A0;
  localparam logic [15:0] DEF_ADDR_WH   = 16'h03A8;

  localparam int ST_VALID = 0;
  localparam int ST_READY = 1;
  localparam int ST_DONE  = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_ERR   = 4;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mulx_shift_add.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first.
// done marks the cycle in which the final bit is being accumulated.
module mulx_shift_add #(
  parameter int OPW = 24
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic [OPW-1:0]     a,
  input  logic [OPW-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [2*OPW-1:0]   product
);

  localparam int RW = 2 * OPW;
  localparam int CW = $clog2(OPW + 1);

  logic [RW-1:0]  mcand_r;
  logic [RW-1:0]  acc_r;
  logic [OPW-1:0] mplier_r;
  logic [CW-1:0]  cnt_r;
  logic           busy_r;
  logic           done_r;

  // Operand snapshot on start, then one accumulate/shift step per busy cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= RW'(a);
      acc_r    <= '0;
      mplier_r <= b;
      cnt_r    <= CW'(OPW);
      busy_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (busy_r) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end else begin
        acc_r <= acc_r;
      end
      mcand_r  <= {mcand_r[RW-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[OPW-1:1]};
      cnt_r    <= cnt_r - CW'(1);
      done_r   <= (cnt_r == CW'(2));
      busy_r   <= (cnt_r != CW'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/gpioemu_mulx.sv
// GPIO-emulator arithmetic peripheral: bus-mapped operands, shift-add product,
// product popcount, status word, GPIO input latch and completed-operation counter.
module gpioemu_mulx
  import gpioemu_pkg::*;
#(
  parameter int          OPW       = 24,
  parameter logic [15:0] ADDR_A1   = DEF_ADDR_A1,
  parameter logic [15:0] ADDR_A2   = DEF_ADDR_A2,
  parameter logic [15:0] ADDR_W    = DEF_ADDR_W,
  parameter logic [15:0] ADDR_L    = DEF_ADDR_L,
  parameter logic [15:0] ADDR_CTRL = DEF_ADDR_CTRL,
  parameter logic [15:0] ADDR_WH   = DEF_ADDR_WH
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out
);

  localparam int RW  = 2 * OPW;
  localparam int PCW = $clog2(RW + 1);
  localparam logic [31:0] OP_MASK = 32'((64'd1 << OPW) - 64'd1);

  state_e         state_r;
  logic [31:0]    a1_r, a2_r, w_r, wh_r, gpio_out_r, snap_r, rdata_r;
  logic [PCW-1:0] l_r;
  logic           valid_r, ready_r, done_r, busy_r, err_r, latch_prev_r;
  logic [31:0]    status_s, rd_data_s;
  logic           wr_ctrl_s, start_s, mul_busy_s, mul_done_s;
  logic [RW-1:0]  mul_product_s;
  logic [63:0]    prod64_s;

  assign wr_ctrl_s = swr && (saddress == ADDR_CTRL);
  assign start_s   = wr_ctrl_s && (state_r == IDLE);
  // Zero-extending to 64 bits lets the low/high word split work for any OPW.
  assign prod64_s  = 64'(mul_product_s);

  mulx_shift_add #(.OPW(OPW)) u_mul (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start_s),
    .a       (a1_r[OPW-1:0]),
    .b       (a2_r[OPW-1:0]),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Status word assembly.
  always_comb begin
    status_s           = 32'd0;
    status_s[ST_VALID] = valid_r;
    status_s[ST_READY] = ready_r;
    status_s[ST_DONE]  = done_r;
    status_s[ST_BUSY]  = busy_r;
    status_s[ST_ERR]   = err_r;
  end

  // Read data select; unmapped addresses read zero.
  always_comb begin
    rd_data_s = 32'd0;
    case (saddress)
      ADDR_A1:   rd_data_s = a1_r;
      ADDR_A2:   rd_data_s = a2_r;
      ADDR_W:    rd_data_s = w_r;
      ADDR_L:    rd_data_s = 32'(l_r);
      ADDR_CTRL: rd_data_s = status_s;
      ADDR_WH:   rd_data_s = wh_r;
      default:   rd_data_s = 32'd0;
    endcase
  end

  // Operand registers and registered read port.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_r    <= 32'd0;
      a2_r    <= 32'd0;
      rdata_r <= 32'd0;
    end else begin
      if (swr && (saddress == ADDR_A1)) a1_r <= sdata_in & OP_MASK;
      if (swr && (saddress == ADDR_A2)) a2_r <= sdata_in & OP_MASK;
      if (srd) rdata_r <= rd_data_s;
    end
  end

  // GPIO capture on a rising edge of gpio_latch.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      snap_r       <= 32'd0;
      latch_prev_r <= 1'b0;
    end else begin
      latch_prev_r <= gpio_latch;
      if (gpio_latch && !latch_prev_r) snap_r <= gpio_in;
    end
  end

  // Operation sequencer with result and status registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r    <= IDLE;
      w_r        <= 32'd0;
      wh_r       <= 32'd0;
      l_r        <= '0;
      valid_r    <= 1'b1;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      gpio_out_r <= 32'd0;
    end else begin
      if (wr_ctrl_s && (state_r != IDLE)) err_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            w_r     <= 32'd0;
            wh_r    <= 32'd0;
            l_r     <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
            valid_r <= 1'b1;
            state_r <= MULT;
          end
        end
        MULT: begin
          if (mul_busy_s && mul_done_s) state_r <= COUNT;
        end
        COUNT: begin
          w_r     <= prod64_s[31:0];
          wh_r    <= prod64_s[63:32];
          l_r     <= PCW'(popcount64(prod64_s));
          valid_r <= (prod64_s[63:32] == 32'd0);
          state_r <= DONE;
        end
        DONE: begin
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          ready_r    <= 1'b1;
          gpio_out_r <= gpio_out_r + 32'd1;
          state_r    <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign sdata_out      = rdata_r;
  assign gpio_out       = gpio_out_r;
  assign gpio_in_s_insp = snap_r;

endmodule

// File: tb/tb_gpioemu_mulx.sv
// Randomised scoreboard bench for gpioemu_mulx against a cycle-level behavioural model.
module tb_gpioemu_mulx;

  localparam int OPW = 24;
  localparam logic [15:0] A_A1   = 16'h037F;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_W    = 16'h0390;
  localparam logic [15:0] A_L    = 16'h0398;
  localparam logic [15:0] A_CTRL = 16'h03A0;
  localparam logic [15:0] A_WH   = 16'h03A8;
  localparam logic [31:0] MASK   = 32'((64'd1 << OPW) - 64'd1);

  logic        clk = 1'b0;
  logic        n_reset, srd, swr, gpio_latch;
  logic [15:0] saddress;
  logic [31:0] sdata_in, sdata_out, gpio_in, gpio_in_s_insp, gpio_out;

  gpioemu_mulx #(.OPW(OPW)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_in_s_insp (gpio_in_s_insp),
    .gpio_out       (gpio_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] exp;
    logic [15:0] addr;
  } rd_t;
  rd_t sb_q[$];
  bit  rd_seen = 1'b0;

  // Behavioural model state
  logic [31:0] m_a1, m_a2, m_w, m_wh, m_l, m_cnt, m_snap;
  logic [63:0] m_prod;
  bit          m_busy, m_done, m_err, m_valid, m_prev_latch;
  int          m_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_a1 = 32'd0; m_a2 = 32'd0; m_w = 32'd0; m_wh = 32'd0; m_l = 32'd0;
    m_cnt = 32'd0; m_snap = 32'd0; m_prod = 64'd0;
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_valid = 1'b1;
    m_prev_latch = 1'b0; m_t = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    case (a)
      A_A1:    return m_a1;
      A_A2:    return m_a2;
      A_W:     return m_w;
      A_L:     return m_l;
      A_CTRL:  return {27'd0, m_err, m_busy, m_done, ~m_busy, m_valid};
      A_WH:    return m_wh;
      default: return 32'd0;
    endcase
  endfunction

  // Applies the spec rules for one clock edge, using pre-edge state for reads.
  task automatic model_step();
    bit  was_busy;
    rd_t e;
    was_busy = m_busy;
    if (srd) begin
      e.exp  = model_read(saddress);
      e.addr = saddress;
      sb_q.push_back(e);
      rd_seen = 1'b1;
    end
    if (gpio_latch && !m_prev_latch) m_snap = gpio_in;
    m_prev_latch = gpio_latch;
    if (swr) begin
      if (saddress == A_A1) m_a1 = sdata_in & MASK;
      if (saddress == A_A2) m_a2 = sdata_in & MASK;
      if (saddress == A_CTRL) begin
        if (was_busy) m_err = 1'b1;
        else begin
          m_prod  = {32'd0, m_a1} * {32'd0, m_a2};
          m_w = 32'd0; m_wh = 32'd0; m_l = 32'd0;
          m_done = 1'b0; m_err = 1'b0; m_valid = 1'b1;
          m_busy = 1'b1; m_t = 0;
        end
      end
    end
    if (was_busy) begin
      m_t++;
      if (m_t == OPW + 1) begin
        m_w     = m_prod[31:0];
        m_wh    = m_prod[63:32];
        m_l     = 32'($countones(m_prod));
        m_valid = (m_prod[63:32] == 32'd0);
      end
      if (m_t == OPW + 2) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_cnt  = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_rd(input logic [15:0] a);
    saddress = a; srd = 1'b1;
    cycle();
    srd = 1'b0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b1;
    cycle();
    swr = 1'b0;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    model_reset();
    sb_q.delete();
    rd_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic read_results();
    bus_rd(A_W); bus_rd(A_WH); bus_rd(A_L); bus_rd(A_CTRL); bus_rd(A_A1); bus_rd(A_A2);
    idle(1);
    check("gpio_out", gpio_out, m_cnt);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 6))
      0:       return A_A1;
      1:       return A_A2;
      2:       return A_W;
      3:       return A_L;
      4:       return A_CTRL;
      5:       return A_WH;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard monitor: sdata_out is valid the cycle after a read strobe.
  always @(negedge clk) begin
    if (rd_seen) begin
      rd_seen = 1'b0;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_underflow: got read data 0x%08h expected no read", sdata_out);
      end else begin
        rd_t e;
        e = sb_q.pop_front();
        check($sformatf("rd_%04h", e.addr), sdata_out, e.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_reset = 1'b0; saddress = 16'd0; srd = 1'b0; swr = 1'b0;
    sdata_in = 32'd0; gpio_in = 32'd0; gpio_latch = 1'b0;
    #2;
    do_reset();

    // Reset state
    bus_rd(A_CTRL); bus_rd(A_W); bus_rd(A_L); bus_rd(A_WH); bus_rd(16'h0000);
    idle(1);
    check("gpio_out_rst", gpio_out, 32'd0);
    check("gpio_snap_rst", gpio_in_s_insp, 32'd0);

    // 3*5, status checked every cycle to pin the latency
    bus_wr(A_A1, 32'd3); bus_wr(A_A2, 32'd5); bus_wr(A_CTRL, 32'd0);
    repeat (OPW + 3) bus_rd(A_CTRL);
    read_results();

    // Full-width operands, upper write bits ignored
    bus_wr(A_A1, 32'hFFFF_FFFF); bus_wr(A_A2, 32'h00FF_FFFF); bus_wr(A_CTRL, 32'd1);
    repeat (OPW + 3) bus_rd(A_CTRL);
    read_results();

    // Second start while busy sets err and does not restart
    bus_wr(A_A1, 32'd7); bus_wr(A_A2, 32'd9); bus_wr(A_CTRL, 32'd0);
    repeat (4) bus_rd(A_CTRL);
    bus_wr(A_CTRL, 32'd0);
    repeat (OPW) bus_rd(A_CTRL);
    read_results();

    // GPIO latch edge capture
    gpio_in = 32'hA5A5_5A5A; gpio_latch = 1'b1;
    cycle();
    check("gpio_capture", gpio_in_s_insp, m_snap);
    gpio_in = 32'h0000_0001;
    idle(3);
    check("gpio_hold", gpio_in_s_insp, m_snap);
    gpio_latch = 1'b0;
    cycle();
    gpio_latch = 1'b1;
    cycle();
    check("gpio_recapture", gpio_in_s_insp, m_snap);

    // Randomised operations with concurrent traffic
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (k == 0) rb = 32'd0;
      if (k == 1) ra = 32'hFFFF_FFFF;
      bus_wr(A_A1, ra);
      saddress = A_A2; sdata_in = rb; srd = 1'b1; swr = 1'b1;
      cycle();
      srd = 1'b0; swr = 1'b0;
      bus_wr(A_CTRL, $urandom);
      for (int c = 0; c < OPW + 3; c++) begin
        if (c == 7) bus_wr(A_A1, $urandom);
        else bus_rd(rand_addr());
      end
      read_results();
    end

    // Reset mid-operation, then a clean operation
    bus_wr(A_A1, 32'd11); bus_wr(A_A2, 32'd13); bus_wr(A_CTRL, 32'd0);
    idle(9);
    do_reset();
    bus_rd(A_CTRL); bus_rd(A_W); bus_rd(A_A1);
    idle(1);
    check("gpio_out_abort", gpio_out, 32'd0);
    bus_wr(A_A1, 32'd3); bus_wr(A_A2, 32'd5); bus_wr(A_CTRL, 32'd0);
    repeat (OPW + 3) bus_rd(A_CTRL);
    read_results();

    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending reads expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
